// File: rtl/alu_issue_pkg.sv
// Shared definitions for the ALU issue stage: operation codes, the
// "no register" address, the stage-register payload and its bubble value.
package alu_issue_pkg;

    localparam int unsigned DATA_W = 16;
    localparam int unsigned OP_W   = 4;
    localparam int unsigned REG_W  = 4;

    localparam logic [OP_W-1:0] OP_ADD   = 4'b0000;
    localparam logic [OP_W-1:0] OP_SUB   = 4'b0001;
    localparam logic [OP_W-1:0] OP_AND   = 4'b0010;
    localparam logic [OP_W-1:0] OP_OR    = 4'b0011;
    localparam logic [OP_W-1:0] OP_NOT   = 4'b0100;
    localparam logic [OP_W-1:0] OP_SRA   = 4'b0101;
    localparam logic [OP_W-1:0] OP_SLL   = 4'b0110;
    localparam logic [OP_W-1:0] OP_SLT   = 4'b0111;
    localparam logic [OP_W-1:0] OP_ZERO  = 4'b1000;
    localparam logic [OP_W-1:0] OP_PASSA = 4'b1001;
    localparam logic [OP_W-1:0] OP_LNOT  = 4'b1010;
    localparam logic [OP_W-1:0] OP_NEQ   = 4'b1011;
    localparam logic [OP_W-1:0] OP_PASSB = 4'b1100;

    localparam logic [REG_W-1:0] REG_NONE = 4'hF;

    typedef struct packed {
        logic              valid;
        logic [OP_W-1:0]   op;
        logic [REG_W-1:0]  rs_addr;
        logic [REG_W-1:0]  rt_addr;
        logic [DATA_W-1:0] rs_val;
        logic [DATA_W-1:0] rt_val;
        logic [DATA_W-1:0] imm;
        logic              use_imm;
        logic [REG_W-1:0]  rd;
        logic              reg_write;
        logic              mem_read;
    } stage_t;

    // Source addresses are parked at REG_NONE so a bubble never picks up bypass data.
    localparam stage_t STAGE_BUBBLE = '{
        valid:     1'b0,
        op:        OP_ZERO,
        rs_addr:   REG_NONE,
        rt_addr:   REG_NONE,
        rs_val:    16'h0000,
        rt_val:    16'h0000,
        imm:       16'h0000,
        use_imm:   1'b0,
        rd:        REG_NONE,
        reg_write: 1'b0,
        mem_read:  1'b0
    };

endpackage

// File: rtl/alu_issue_fwd_mux.sv
// Bypass selection for one ALU source operand.
// Ports: src_addr/src_val (stored register number and value),
//        exm_* / mwb_* (forwarding sources), fwd_val (selected operand).
module fwd_mux
    import alu_issue_pkg::*;
(
    input  logic [REG_W-1:0]  src_addr,
    input  logic [DATA_W-1:0] src_val,
    input  logic              exm_wr,
    input  logic [REG_W-1:0]  exm_rd,
    input  logic [DATA_W-1:0] exm_data,
    input  logic              mwb_wr,
    input  logic [REG_W-1:0]  mwb_rd,
    input  logic [DATA_W-1:0] mwb_data,
    output logic [DATA_W-1:0] fwd_val
);

    // EX/MEM is the younger result, so it wins over MEM/WB.
    always_comb begin
        fwd_val = src_val;
        if (src_addr != REG_NONE) begin
            if (exm_wr && (exm_rd == src_addr)) begin
                fwd_val = exm_data;
            end else if (mwb_wr && (mwb_rd == src_addr)) begin
                fwd_val = mwb_data;
            end
        end
    end

endmodule

// File: rtl/alu_issue.sv
// ALU issue stage: decode-to-execute pipeline register with operand bypass
// and load-use hazard detection.
// Ports: clk/rst; id_* decoded instruction; stall/flush pipeline control;
//        exm_*/mwb_* forwarding sources; alu_first/alu_second/alu_op to the
//        ALU; ex_* registered control to EX/MEM; load_use_stall hazard request.
module alu_issue
    import alu_issue_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid,
    input  logic [OP_W-1:0]   id_op,
    input  logic [REG_W-1:0]  id_rs_addr,
    input  logic [REG_W-1:0]  id_rt_addr,
    input  logic [DATA_W-1:0] id_rs_val,
    input  logic [DATA_W-1:0] id_rt_val,
    input  logic [DATA_W-1:0] id_imm,
    input  logic              id_use_imm,
    input  logic [REG_W-1:0]  id_rd_addr,
    input  logic              id_reg_write,
    input  logic              id_mem_read,
    input  logic              stall,
    input  logic              flush,
    input  logic              exm_wr,
    input  logic [REG_W-1:0]  exm_rd,
    input  logic [DATA_W-1:0] exm_data,
    input  logic              mwb_wr,
    input  logic [REG_W-1:0]  mwb_rd,
    input  logic [DATA_W-1:0] mwb_data,
    output logic [DATA_W-1:0] alu_first,
    output logic [DATA_W-1:0] alu_second,
    output logic [OP_W-1:0]   alu_op,
    output logic              ex_valid,
    output logic [REG_W-1:0]  ex_rd,
    output logic              ex_reg_write,
    output logic              ex_mem_read,
    output logic              load_use_stall
);

    stage_t stage_q, stage_d;
    logic [DATA_W-1:0] rs_fwd, rt_fwd;

    // Load in EX whose destination is read by the instruction in decode.
    always_comb begin
        load_use_stall = stage_q.valid && stage_q.mem_read && id_valid &&
                         (stage_q.rd != REG_NONE) &&
                         ((stage_q.rd == id_rs_addr) ||
                          ((stage_q.rd == id_rt_addr) && !id_use_imm));
    end

    // Next stage contents: flush > stall > bubble (hazard/no instr) > load.
    always_comb begin
        stage_d = stage_q;
        if (flush) begin
            stage_d = STAGE_BUBBLE;
        end else if (stall) begin
            stage_d = stage_q;
        end else if (load_use_stall || !id_valid) begin
            stage_d = STAGE_BUBBLE;
        end else begin
            stage_d.valid     = 1'b1;
            stage_d.op        = id_op;
            stage_d.rs_addr   = id_rs_addr;
            stage_d.rt_addr   = id_rt_addr;
            stage_d.rs_val    = id_rs_val;
            stage_d.rt_val    = id_rt_val;
            stage_d.imm       = id_imm;
            stage_d.use_imm   = id_use_imm;
            stage_d.rd        = id_rd_addr;
            stage_d.reg_write = id_reg_write;
            stage_d.mem_read  = id_mem_read;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stage_q <= STAGE_BUBBLE;
        end else begin
            stage_q <= stage_d;
        end
    end

    fwd_mux u_fwd_rs (
        .src_addr (stage_q.rs_addr),
        .src_val  (stage_q.rs_val),
        .exm_wr   (exm_wr),
        .exm_rd   (exm_rd),
        .exm_data (exm_data),
        .mwb_wr   (mwb_wr),
        .mwb_rd   (mwb_rd),
        .mwb_data (mwb_data),
        .fwd_val  (rs_fwd)
    );

    fwd_mux u_fwd_rt (
        .src_addr (stage_q.rt_addr),
        .src_val  (stage_q.rt_val),
        .exm_wr   (exm_wr),
        .exm_rd   (exm_rd),
        .exm_data (exm_data),
        .mwb_wr   (mwb_wr),
        .mwb_rd   (mwb_rd),
        .mwb_data (mwb_data),
        .fwd_val  (rt_fwd)
    );

    always_comb begin
        alu_first    = rs_fwd;
        alu_second   = stage_q.use_imm ? stage_q.imm : rt_fwd;
        alu_op       = stage_q.op;
        ex_valid     = stage_q.valid;
        ex_rd        = stage_q.rd;
        ex_reg_write = stage_q.reg_write;
        ex_mem_read  = stage_q.mem_read;
    end

endmodule

// File: tb/tb_alu_issue.sv
// Directed-vector bench for alu_issue.
module tb_alu_issue;

    logic        clk = 1'b0;
    logic        rst;
    logic        id_valid;
    logic [3:0]  id_op;
    logic [3:0]  id_rs_addr, id_rt_addr;
    logic [15:0] id_rs_val, id_rt_val, id_imm;
    logic        id_use_imm;
    logic [3:0]  id_rd_addr;
    logic        id_reg_write, id_mem_read;
    logic        stall, flush;
    logic        exm_wr, mwb_wr;
    logic [3:0]  exm_rd, mwb_rd;
    logic [15:0] exm_data, mwb_data;
    logic [15:0] alu_first, alu_second;
    logic [3:0]  alu_op;
    logic        ex_valid;
    logic [3:0]  ex_rd;
    logic        ex_reg_write, ex_mem_read, load_use_stall;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    alu_issue dut (
        .clk(clk), .rst(rst),
        .id_valid(id_valid), .id_op(id_op),
        .id_rs_addr(id_rs_addr), .id_rt_addr(id_rt_addr),
        .id_rs_val(id_rs_val), .id_rt_val(id_rt_val),
        .id_imm(id_imm), .id_use_imm(id_use_imm),
        .id_rd_addr(id_rd_addr), .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
        .stall(stall), .flush(flush),
        .exm_wr(exm_wr), .exm_rd(exm_rd), .exm_data(exm_data),
        .mwb_wr(mwb_wr), .mwb_rd(mwb_rd), .mwb_data(mwb_data),
        .alu_first(alu_first), .alu_second(alu_second), .alu_op(alu_op),
        .ex_valid(ex_valid), .ex_rd(ex_rd), .ex_reg_write(ex_reg_write),
        .ex_mem_read(ex_mem_read), .load_use_stall(load_use_stall)
    );

    task automatic present(input logic v, input logic [3:0] op,
                           input logic [3:0] rs, input logic [15:0] rsv,
                           input logic [3:0] rt, input logic [15:0] rtv,
                           input logic [15:0] imm, input logic ui,
                           input logic [3:0] rd, input logic rw, input logic mr);
        id_valid = v; id_op = op;
        id_rs_addr = rs; id_rs_val = rsv;
        id_rt_addr = rt; id_rt_val = rtv;
        id_imm = imm; id_use_imm = ui;
        id_rd_addr = rd; id_reg_write = rw; id_mem_read = mr;
    endtask

    task automatic clear_fwd();
        exm_wr = 0; exm_rd = 4'h0; exm_data = 16'h0;
        mwb_wr = 0; mwb_rd = 4'h0; mwb_data = 16'h0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        n_checks++; if (ex_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", ex_valid); end
        n_checks++; if (alu_op !== 4'b1000) begin n_fail++; $display("FAIL reset_op: got %b want 1000", alu_op); end
        n_checks++; if (ex_rd !== 4'hF) begin n_fail++; $display("FAIL reset_rd: got %h want f", ex_rd); end
        n_checks++; if (ex_reg_write !== 1'b0 || ex_mem_read !== 1'b0) begin n_fail++; $display("FAIL reset_ctl: got rw=%b mr=%b want 0 0", ex_reg_write, ex_mem_read); end
        n_checks++; if (alu_first !== 16'h0000 || alu_second !== 16'h0000) begin n_fail++; $display("FAIL reset_ops: got %h %h want 0000 0000", alu_first, alu_second); end
        n_checks++; if (load_use_stall !== 1'b0) begin n_fail++; $display("FAIL reset_lus: got %b want 0", load_use_stall); end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_add();
        present(1, 4'b0000, 4'h1, 16'h0005, 4'h2, 16'h0003, 16'h0000, 0, 4'h5, 1, 0);
        tick();
        n_checks++; if (alu_first !== 16'h0005) begin n_fail++; $display("FAIL add_first: got %h want 0005", alu_first); end
        n_checks++; if (alu_second !== 16'h0003) begin n_fail++; $display("FAIL add_second: got %h want 0003", alu_second); end
        n_checks++; if (alu_op !== 4'b0000) begin n_fail++; $display("FAIL add_op: got %b want 0000", alu_op); end
        n_checks++; if (ex_valid !== 1'b1 || ex_rd !== 4'h5 || ex_reg_write !== 1'b1) begin n_fail++; $display("FAIL add_ctl: got v=%b rd=%h rw=%b want 1 5 1", ex_valid, ex_rd, ex_reg_write); end
    endtask

    task automatic test_forward();
        present(1, 4'b0011, 4'h3, 16'h1111, 4'h6, 16'h2222, 16'h0000, 0, 4'h7, 1, 0);
        tick();
        exm_wr = 1; exm_rd = 4'h3; exm_data = 16'h1234;
        mwb_wr = 1; mwb_rd = 4'h3; mwb_data = 16'hBEEF;
        #1;
        n_checks++; if (alu_first !== 16'h1234) begin n_fail++; $display("FAIL fwd_exm_wins: got %h want 1234", alu_first); end
        n_checks++; if (alu_second !== 16'h2222) begin n_fail++; $display("FAIL fwd_rt_nomatch: got %h want 2222", alu_second); end
        exm_wr = 0;
        #1;
        n_checks++; if (alu_first !== 16'hBEEF) begin n_fail++; $display("FAIL fwd_mwb: got %h want beef", alu_first); end
        mwb_rd = 4'h6;
        #1;
        n_checks++; if (alu_first !== 16'h1111 || alu_second !== 16'hBEEF) begin n_fail++; $display("FAIL fwd_rt_mwb: got %h %h want 1111 beef", alu_first, alu_second); end
        clear_fwd();
    endtask

    task automatic test_imm();
        // Load to r2 sitting in the stage.
        present(1, 4'b0000, 4'h1, 16'h0000, 4'hF, 16'h0000, 16'h0000, 0, 4'h2, 1, 1);
        tick();
        present(1, 4'b0000, 4'h7, 16'h0070, 4'h2, 16'h0022, 16'h0000, 0, 4'h8, 1, 0);
        #1;
        n_checks++; if (load_use_stall !== 1'b1) begin n_fail++; $display("FAIL lus_rt: got %b want 1", load_use_stall); end
        present(1, 4'b0000, 4'h7, 16'h0070, 4'h2, 16'h0022, 16'hFFF0, 1, 4'h8, 1, 0);
        #1;
        n_checks++; if (load_use_stall !== 1'b0) begin n_fail++; $display("FAIL lus_imm: got %b want 0", load_use_stall); end
        tick();
        exm_wr = 1; exm_rd = 4'h2; exm_data = 16'h5555;
        #1;
        n_checks++; if (alu_second !== 16'hFFF0) begin n_fail++; $display("FAIL imm_second: got %h want fff0", alu_second); end
        n_checks++; if (alu_first !== 16'h0070 || ex_valid !== 1'b1) begin n_fail++; $display("FAIL imm_first: got %h v=%b want 0070 1", alu_first, ex_valid); end
        clear_fwd();
    endtask

    task automatic test_load_use();
        present(1, 4'b0000, 4'h1, 16'h0000, 4'hF, 16'h0000, 16'h0000, 0, 4'h4, 1, 1);
        tick();
        n_checks++; if (ex_mem_read !== 1'b1 || ex_rd !== 4'h4) begin n_fail++; $display("FAIL lu_load: got mr=%b rd=%h want 1 4", ex_mem_read, ex_rd); end
        present(1, 4'b0001, 4'h4, 16'h0009, 4'h2, 16'h0001, 16'h0000, 0, 4'h6, 1, 0);
        #1;
        n_checks++; if (load_use_stall !== 1'b1) begin n_fail++; $display("FAIL lu_detect: got %b want 1", load_use_stall); end
        tick();
        n_checks++; if (ex_valid !== 1'b0 || alu_op !== 4'b1000 || ex_rd !== 4'hF) begin n_fail++; $display("FAIL lu_bubble: got v=%b op=%b rd=%h want 0 1000 f", ex_valid, alu_op, ex_rd); end
        n_checks++; if (load_use_stall !== 1'b0) begin n_fail++; $display("FAIL lu_release: got %b want 0", load_use_stall); end
        tick();
        n_checks++; if (ex_valid !== 1'b1 || alu_first !== 16'h0009 || alu_op !== 4'b0001) begin n_fail++; $display("FAIL lu_reissue: got v=%b a=%h op=%b want 1 0009 0001", ex_valid, alu_first, alu_op); end
        // A load with no destination never raises the hazard, even against rs=F.
        present(1, 4'b0000, 4'h1, 16'h0000, 4'hF, 16'h0000, 16'h0000, 0, 4'hF, 0, 1);
        tick();
        present(1, 4'b0000, 4'hF, 16'h0000, 4'hF, 16'h0000, 16'h0000, 0, 4'h3, 1, 0);
        #1;
        n_checks++; if (load_use_stall !== 1'b0) begin n_fail++; $display("FAIL lu_none: got %b want 0", load_use_stall); end
    endtask

    task automatic test_stall();
        present(1, 4'b0001, 4'h1, 16'h00AA, 4'h2, 16'h0000, 16'h0000, 0, 4'h3, 1, 0);
        tick();
        present(1, 4'b0011, 4'h1, 16'h00BB, 4'h2, 16'h0000, 16'h0000, 0, 4'h9, 1, 0);
        stall = 1;
        tick();
        n_checks++; if (alu_op !== 4'b0001 || alu_first !== 16'h00AA || ex_rd !== 4'h3) begin n_fail++; $display("FAIL stall_hold: got op=%b a=%h rd=%h want 0001 00aa 3", alu_op, alu_first, ex_rd); end
        stall = 0;
    endtask

    task automatic test_stall_flush();
        present(1, 4'b0010, 4'h1, 16'h0001, 4'h2, 16'h0002, 16'h0000, 0, 4'h5, 1, 0);
        tick();
        n_checks++; if (ex_reg_write !== 1'b1) begin n_fail++; $display("FAIL sf_pre: got %b want 1", ex_reg_write); end
        stall = 1; flush = 1;
        tick();
        n_checks++; if (ex_valid !== 1'b0 || ex_reg_write !== 1'b0 || alu_op !== 4'b1000 || ex_rd !== 4'hF) begin n_fail++; $display("FAIL sf_bubble: got v=%b rw=%b op=%b rd=%h want 0 0 1000 f", ex_valid, ex_reg_write, alu_op, ex_rd); end
        stall = 0; flush = 0;
        present(0, 4'b0000, 4'h1, 16'h0001, 4'h2, 16'h0002, 16'h0000, 0, 4'h5, 1, 0);
        tick();
        n_checks++; if (ex_valid !== 1'b0 || ex_reg_write !== 1'b0) begin n_fail++; $display("FAIL idle_bubble: got v=%b rw=%b want 0 0", ex_valid, ex_reg_write); end
    endtask

    task automatic test_reset_mid_stall();
        present(1, 4'b0000, 4'h1, 16'h4321, 4'h2, 16'h0000, 16'h0000, 0, 4'h5, 1, 0);
        tick();
        stall = 1;
        tick();
        #2 rst = 1;
        #1;
        n_checks++; if (alu_first !== 16'h0000 || ex_valid !== 1'b0 || alu_op !== 4'b1000) begin n_fail++; $display("FAIL rst_async: got a=%h v=%b op=%b want 0000 0 1000", alu_first, ex_valid, alu_op); end
        rst = 0;
        tick();
        n_checks++; if (ex_valid !== 1'b0) begin n_fail++; $display("FAIL rst_then_stall: got %b want 0", ex_valid); end
        stall = 0;
        tick();
        n_checks++; if (ex_valid !== 1'b1 || alu_first !== 16'h4321) begin n_fail++; $display("FAIL rst_resume: got v=%b a=%h want 1 4321", ex_valid, alu_first); end
    endtask

    initial begin
        rst = 1; stall = 0; flush = 0;
        present(0, 4'h0, 4'h0, 16'h0, 4'h0, 16'h0, 16'h0, 0, 4'hF, 0, 0);
        clear_fwd();
        test_reset();
        test_add();
        test_forward();
        test_imm();
        test_load_use();
        test_stall();
        test_stall_flush();
        test_reset_mid_stall();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_issue.md
ALU_ISSUE -- requirements
Module: alu_issue

Interface
REQ-001 clk  input  1  single system clock; all state updates on its rising edge.
REQ-002 rst  input  1  asynchronous, active-high reset.
REQ-003 id_valid  input  1  decode stage presents an instruction this cycle.
REQ-004 id_op  input  4  ALU operation code for the decoded instruction.
REQ-005 id_rs_addr, id_rt_addr  input  4 each  source register numbers; 4'hF means "no register".
REQ-006 id_rs_val, id_rt_val  input  16 each  register-file read data.
REQ-007 id_imm  input  16  sign/zero-extended immediate, already formatted by decode.
REQ-008 id_use_imm  input  1  second operand is id_imm instead of rt.
REQ-009 id_rd_addr  input  4  destination register; 4'hF means none.
REQ-010 id_reg_write, id_mem_read  input  1 each  writeback enable; instruction is a load.
REQ-011 stall  input  1  downstream hold request; stage register keeps its contents.
REQ-012 flush  input  1  branch/jump squash request.
REQ-013 exm_wr, exm_rd, exm_data  input  1/4/16  EX/MEM forwarding source.
REQ-014 mwb_wr, mwb_rd, mwb_data  input  1/4/16  MEM/WB forwarding source.
REQ-015 alu_first, alu_second  output  16 each  operands driven to the ALU.
REQ-016 alu_op  output  4  operation code driven to the ALU.
REQ-017 ex_valid, ex_rd, ex_reg_write, ex_mem_read  output  1/4/1/1  registered control forwarded to EX/MEM.
REQ-018 load_use_stall  output  1  request to the fetch/decode stages to hold for one cycle.

Function
REQ-019 Stage register (valid, op, rs/rt addr and value, imm, use_imm, rd, reg_write, mem_read) SHALL load on the rising edge when stall=0, flush=0, load_use_stall=0.
REQ-020 flush=1 SHALL load a bubble on the next edge: valid=0, op=4'b1000 (zero), rd=4'hF, reg_write=0, mem_read=0; flush has priority over stall.
REQ-021 stall=1 with flush=0 SHALL hold every stage bit unchanged.
REQ-022 load_use_stall SHALL be combinational = ex_valid & ex_mem_read & id_valid & ex_rd!=4'hF & (ex_rd==id_rs_addr | (ex_rd==id_rt_addr & !id_use_imm)).
REQ-023 load_use_stall=1 with stall=0 and flush=0 SHALL load a bubble (as REQ-020); decode holds its instruction externally and re-presents it next cycle.
REQ-024 id_valid=0 SHALL load a bubble.
REQ-025 Operand bypass SHALL be combinational from stage register: for rs, use exm_data if exm_wr & exm_rd==rs_addr & rs_addr!=4'hF; else mwb_data if mwb_wr & mwb_rd==rs_addr & rs_addr!=4'hF; else stored rs_val.
REQ-026 Same bypass rule SHALL apply to rt; EX/MEM always wins over MEM/WB on simultaneous match.
REQ-027 alu_second SHALL equal stored imm when use_imm=1, bypassed rt otherwise; alu_first is always bypassed rs.
REQ-028 alu_op SHALL equal stored op; bubble drives 4'b1000.
REQ-029 Latency: decode to ALU inputs exactly one cycle when no stall/flush.
REQ-030 All data paths 16 bit; no width extension or truncation inside the block.

Reset
REQ-031 rst=1 SHALL asynchronously force the stage register to the bubble value of REQ-020; all stored values 16'h0000.
REQ-032 Reset mid-stall or mid-flush SHALL override both; first edge after release obeys REQ-019..024.

Structure
REQ-033 Shared package SHALL hold ALU op constants (ADD 0000, SUB 0001, AND 0010, OR 0011, NOT 0100, SRA 0101, SLL 0110, SLT 0111, ZERO 1000, PASSA 1001, LNOT 1010, NEQ 1011, PASSB 1100), REG_NONE=4'hF, and the bubble value.
REQ-034 One sub-module, fwd_mux (one operand's bypass selection), instantiated twice.

Verification
REQ-035 ADD, rs=1 (16'h0005), rt=2 (16'h0003), no forwarding -> next cycle alu_first=0005, alu_second=0003, alu_op=0000.
REQ-036 rs=3, exm_wr=1 exm_rd=3 exm_data=16'h1234, mwb_wr=1 mwb_rd=3 mwb_data=16'hBEEF -> alu_first=1234.
REQ-037 Load to r4 in stage, decode presents rs=4 -> load_use_stall=1, next cycle ex_valid=0, alu_op=1000.
REQ-038 stall=1 and flush=1 same cycle -> bubble loaded, ex_reg_write=0.
REQ-039 use_imm=1, imm=16'hFFF0, rt=4'h2 matching exm_rd -> alu_second=FFF0, no load_use_stall from rt.
REQ-040 rst pulsed between edges during stall -> outputs immediately bubble, alu_first=0000.
